dmem_line_responder: RTL and testbench
======================================

Name: dmem_line_responder

Overview:
- Backing-memory responder on the far end of the data-cache miss/fill interface.
- Accepts one 256-bit cache-line request at a time (line read for refill, or full-line write-back), applies a fixed programmable latency, and returns the line on a valid/retry ack channel.
- Replaces the testbench-side memory model in the lab5 integrated core.

Parameters:
- LATENCY, 4, cycles spent in BUSY per request; legal range 1..255.
- ADDR_BITS, 10, log2 of lines held; array depth = 2**ADDR_BITS lines.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- req_addr  in  59  line address (byte address [63:5])
- req_we  in  1  1 = line write, 0 = line read
- req_wdata  in  256  write line data
- req_valid  in  1  request present
- req_retry  out  1  1 = request not accepted this cycle
- ack_data  out  256  read line data
- ack_addr  out  59  line address of the returned line
- ack_valid  out  1  read response present
- ack_retry  in  1  1 = consumer stalls the ack

Behaviour:
- Handshake is valid/retry. A transfer occurs on an edge where valid=1 and retry=0. The producer holds all fields stable while retry=1.
- Reset (async assert, sync release):
  - State goes to IDLE, counter to 0, req_retry=0, ack_valid=0.
  - ack_data and ack_addr go to 0.
  - Array contents are NOT cleared.
- FSM states: IDLE, BUSY, RESP.
  - req_retry = (state != IDLE).
  - IDLE: on accept, latch addr/we/wdata, load cnt = LATENCY-1, go to BUSY.
  - BUSY: if cnt != 0, decrement cnt.
    - If cnt == 0 and the request is a write: write the array at the latched index on this edge, go to IDLE. Writes produce no ack.
    - If cnt == 0 and the request is a read: register array data into ack_data and the latched addr into ack_addr, go to RESP.
  - RESP: ack_valid=1, with ack_data/ack_addr held. If ack_retry=0 at the edge, go to IDLE. Otherwise stay and hold.
- Timing, with acceptance in cycle 0:
  - BUSY spans cycles 1..LATENCY.
  - A read has ack_valid=1 from cycle LATENCY+1.
  - A write updates the array at the end of cycle LATENCY; req_retry=0 again in cycle LATENCY+1.
  - The minimum read round-trip is LATENCY+1 cycles; there is no back-to-back accept in the cycle ack completes.
- Indexing: index = addr[ADDR_BITS-1:0].
  - If addr[58:ADDR_BITS] != 0 (out of range), a read returns the line of eight 32'hdeaddead words and a write is dropped.
  - An out-of-range read still returns on the normal latency schedule, and ack_addr still echoes the address.
- Ordering: strictly one outstanding request. A read accepted after a write to the same line returns the written data.
- req_valid=1 while not in IDLE is ignored (req_retry=1). The caller must hold the request.
- Reset asserted mid-request drops the pending request and any ack. No partial array write occurs unless the write edge already happened.
- The counter is 8 bits wide. LATENCY=1 means cnt=0 on entry, so BUSY lasts exactly one cycle.

Decomposition:
- Package dmem_pkg holds:
  - LINE_BITS=256 and LINE_ADDR_BITS=59.
  - The state enum {IDLE,BUSY,RESP}.
  - DEAD_LINE = {8{32'hdeaddead}}.
- Sub-module dmem_array: 2**ADDR_BITS x 256 storage with combinational read and synchronous write enable, no reset.
- The FSM, latches, counter and ack register live in dmem_line_responder.

Test Plan:
- Reset with req_valid=0 → req_retry=0, ack_valid=0, ack_data=0 while reset=0 and the cycle after release.
- LATENCY=4: write addr 0x3 with data {8{32'h11223344}}, then read addr 0x3 → write accepted cycle 0; req_retry=1 in cycles 1-4 and 0 in cycle 5; read ack_valid=1 exactly 5 cycles after its accept, ack_data={8{32'h11223344}}, ack_addr=0x3.
- Read with ack_retry=1 for 3 cycles → ack_valid stays 1 with data unchanged for 4 cycles; IDLE the cycle after ack_retry drops; req_retry=1 throughout.
- Read addr 59'h400 (bit 10 set, ADDR_BITS=10) → ack_data=DEAD_LINE; a prior write to 0x400 leaves index 0 unchanged.
- LATENCY=1: back-to-back reads to 0x1 and 0x2 with req_valid held → accepts 3 cycles apart; each ack arrives 2 cycles after its accept.
- Drive reset=0 in cycle 2 of BUSY for a write to 0x7 → ack_valid=0, state IDLE, a later read of 0x7 returns the old contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory line responder.
//   LINE_BITS / LINE_ADDR_BITS : cache-line data width and line-address width
//   DEAD_LINE                  : fill pattern returned for out-of-range reads
//   state_t                    : responder FSM states
//   line_req_t                 : request fields captured at acceptance
package dmem_pkg;

  localparam int LINE_BITS      = 256;
  localparam int LINE_ADDR_BITS = 59;

  localparam logic [LINE_BITS-1:0] DEAD_LINE = {8{32'hdeaddead}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef struct packed {
    logic [LINE_ADDR_BITS-1:0] addr;
    logic                      we;
    logic [LINE_BITS-1:0]      wdata;
  } line_req_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2**ADDR_BITS x LINE_BITS line storage.
//   clk   : write clock
//   we    : write enable, line written on the rising edge
//   addr  : line index, shared by read and write
//   wdata : write line data
//   rdata : combinational read of the line at addr
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata
);

  logic [LINE_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: backing memory on the far side of the D-cache
// miss/fill interface. One line request at a time, fixed LATENCY cycles in
// BUSY, read data returned on a valid/retry ack channel.
//   clk, reset  : clock; asynchronous active-low reset
//   req_*       : line request (addr, we, wdata, valid) / req_retry back-pressure
//   ack_*       : read response (data, addr, valid) / ack_retry from consumer
// Addresses with bits above ADDR_BITS set are out of range: reads return
// DEAD_LINE on the normal schedule, writes are dropped.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LINE_ADDR_BITS-1:0] req_addr,
  input  logic                      req_we,
  input  logic [LINE_BITS-1:0]      req_wdata,
  input  logic                      req_valid,
  output logic                      req_retry,
  output logic [LINE_BITS-1:0]      ack_data,
  output logic [LINE_ADDR_BITS-1:0] ack_addr,
  output logic                      ack_valid,
  input  logic                      ack_retry
);

  // BUSY finishes on the edge where cnt is 0, so LATENCY-1 yields LATENCY cycles.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t               state;
  logic [7:0]           cnt;
  line_req_t            lreq;
  logic                 in_range;
  logic                 arr_we;
  logic [LINE_BITS-1:0] arr_rdata;

  assign in_range = (lreq.addr[LINE_ADDR_BITS-1:ADDR_BITS] == '0);
  // Write lands on the final BUSY edge; a reset before then leaves the array untouched.
  assign arr_we   = (state == BUSY) && (cnt == 8'd0) && lreq.we && in_range;

  dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (lreq.addr[ADDR_BITS-1:0]),
    .wdata (lreq.wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lreq      <= '0;
      req_retry <= 1'b0;
      ack_valid <= 1'b0;
      ack_data  <= '0;
      ack_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_retry is 0 here, so a valid request is an accepted one.
          if (req_valid) begin
            lreq      <= '{addr: req_addr, we: req_we, wdata: req_wdata};
            cnt       <= CNT_LOAD;
            req_retry <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (lreq.we) begin
            req_retry <= 1'b0;
            state     <= IDLE;
          end else begin
            ack_data  <= in_range ? arr_rdata : DEAD_LINE;
            ack_addr  <= lreq.addr;
            ack_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (!ack_retry) begin
            ack_valid <= 1'b0;
            req_retry <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          ack_valid <= 1'b0;
          req_retry <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Testbench for dmem_line_responder. Unit 0 runs with LATENCY=4, unit 1 with
// LATENCY=1; both share clock and reset. A line-level memory model (keyed by
// unit and index) supplies expected read data; the cycle schedule is derived
// from LATENCY directly.
module tb_dmem_line_responder;
  localparam int AB = 10;
  localparam logic [255:0] DEAD = {8{32'hdeaddead}};

  logic         clk = 1'b0;
  logic         reset;
  logic [58:0]  req_addr  [2];
  logic         req_we    [2];
  logic [255:0] req_wdata [2];
  logic         req_valid [2];
  logic         req_retry [2];
  logic [255:0] ack_data  [2];
  logic [58:0]  ack_addr  [2];
  logic         ack_valid [2];
  logic         ack_retry [2];

  int lat [2] = '{4, 1};
  int n_chk  = 0;
  int n_fail = 0;
  logic [255:0] model [int];

  always #5 clk = ~clk;

  dmem_line_responder #(.LATENCY(4), .ADDR_BITS(AB)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_addr(req_addr[0]), .req_we(req_we[0]), .req_wdata(req_wdata[0]),
    .req_valid(req_valid[0]), .req_retry(req_retry[0]),
    .ack_data(ack_data[0]), .ack_addr(ack_addr[0]), .ack_valid(ack_valid[0]),
    .ack_retry(ack_retry[0]));

  dmem_line_responder #(.LATENCY(1), .ADDR_BITS(AB)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_addr(req_addr[1]), .req_we(req_we[1]), .req_wdata(req_wdata[1]),
    .req_valid(req_valid[1]), .req_retry(req_retry[1]),
    .ack_data(ack_data[1]), .ack_addr(ack_addr[1]), .ack_valid(ack_valid[1]),
    .ack_retry(ack_retry[1]));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [58:0] rnd_addr();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[58:0];
  endfunction

  function automatic bit in_rng(input logic [58:0] a);
    return (a >> AB) == 0;
  endfunction

  function automatic int key(input int u, input logic [58:0] a);
    return u * 65536 + int'(a % (59'd1 << AB));
  endfunction

  // Full transaction starting at a negedge with the unit idle; returns at the
  // negedge where the unit is idle again.
  task automatic txn(input int u, input logic we, input logic [58:0] addr,
                     input logic [255:0] d, input int stall);
    logic [255:0] exp;
    exp = '0;
    if (!we) exp = in_rng(addr) ? model[key(u, addr)] : DEAD;
    chk("idle_retry", req_retry[u], 1'b0);
    req_addr[u] = addr; req_we[u] = we; req_wdata[u] = d;
    req_valid[u] = 1'b1; ack_retry[u] = 1'b0;
    @(negedge clk);
    // Scramble request fields once accepted; the DUT must use its latched copy.
    req_valid[u] = 1'b0; req_addr[u] = rnd_addr(); req_wdata[u] = rnd_line();
    req_we[u] = $urandom_range(0, 1) == 1;
    for (int c = 1; c <= lat[u]; c++) begin
      if (c > 1) @(negedge clk);
      chk("busy_retry", req_retry[u], 1'b1);
      chk("busy_ackv", ack_valid[u], 1'b0);
    end
    @(negedge clk);
    if (we) begin
      chk("wr_done_retry", req_retry[u], 1'b0);
      chk("wr_no_ack", ack_valid[u], 1'b0);
      if (in_rng(addr)) model[key(u, addr)] = d;
    end else begin
      for (int k = 0; k <= stall; k++) begin
        if (k > 0) @(negedge clk);
        chk("rd_ackv", ack_valid[u], 1'b1);
        chk("rd_data", ack_data[u], exp);
        chk("rd_addr", ack_addr[u], addr);
        chk("rd_retry_hold", req_retry[u], 1'b1);
        ack_retry[u] = (k < stall);
      end
      @(negedge clk);
      chk("rd_done_ackv", ack_valid[u], 1'b0);
      chk("rd_done_retry", req_retry[u], 1'b0);
    end
  endtask

  initial begin
    logic [255:0] l1, l2, oldv, x0;
    logic [58:0]  a;
    bit           w;
    for (int u = 0; u < 2; u++) begin
      req_addr[u] = '0; req_we[u] = 1'b0; req_wdata[u] = '0;
      req_valid[u] = 1'b0; ack_retry[u] = 1'b0;
    end

    // Reset state, during and one cycle after release.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_retry", req_retry[u], 1'b0);
      chk("rst_ackv", ack_valid[u], 1'b0);
      chk("rst_data", ack_data[u], '0);
      chk("rst_addr", ack_addr[u], '0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_retry", req_retry[0], 1'b0);
    chk("post_rst_ackv", ack_valid[0], 1'b0);
    chk("post_rst_data", ack_data[0], '0);

    // Write then read the same line.
    txn(0, 1'b1, 59'h3, {8{32'h11223344}}, 0);
    txn(0, 1'b0, 59'h3, '0, 0);

    // Read held off by ack_retry for three cycles.
    txn(0, 1'b0, 59'h3, '0, 3);

    // Out-of-range write is dropped, out-of-range read returns DEAD_LINE.
    x0 = rnd_line();
    txn(0, 1'b1, 59'h0, x0, 0);
    txn(0, 1'b1, 59'h400, rnd_line(), 0);
    txn(0, 1'b0, 59'h0, '0, 0);
    txn(0, 1'b0, 59'h400, '0, 1);

    // Reset during BUSY of a write: the old line survives.
    oldv = rnd_line();
    txn(0, 1'b1, 59'h7, oldv, 0);
    req_addr[0] = 59'h7; req_we[0] = 1'b1; req_wdata[0] = ~oldv; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_ackv", ack_valid[0], 1'b0);
    chk("midrst_retry", req_retry[0], 1'b0);
    chk("midrst_data", ack_data[0], '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_idle", req_retry[0], 1'b0);
    txn(0, 1'b0, 59'h7, '0, 0);

    // Random traffic on unit 0 over indices 0..7 plus out-of-range aliases.
    for (int i = 0; i < 8; i++) txn(0, 1'b1, 59'(i), rnd_line(), 0);
    for (int t = 0; t < 30; t++) begin
      a = 59'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = a | (59'($urandom_range(1, 255)) << AB);
      w = $urandom_range(0, 1) == 1;
      txn(0, w, a, rnd_line(), $urandom_range(0, 2));
    end

    // LATENCY=1: back-to-back reads with req_valid held high.
    l1 = rnd_line(); l2 = rnd_line();
    txn(1, 1'b1, 59'h1, l1, 0);
    txn(1, 1'b1, 59'h2, l2, 0);
    req_addr[1] = 59'h1; req_we[1] = 1'b0; req_valid[1] = 1'b1; ack_retry[1] = 1'b0;
    chk("b2b_c0_retry", req_retry[1], 1'b0);
    @(negedge clk);
    chk("b2b_c1_retry", req_retry[1], 1'b1);
    chk("b2b_c1_ackv", ack_valid[1], 1'b0);
    req_addr[1] = 59'h2;
    @(negedge clk);
    chk("b2b_c2_ackv", ack_valid[1], 1'b1);
    chk("b2b_c2_data", ack_data[1], l1);
    chk("b2b_c2_addr", ack_addr[1], 59'h1);
    chk("b2b_c2_retry", req_retry[1], 1'b1);
    @(negedge clk);
    chk("b2b_c3_retry", req_retry[1], 1'b0);
    chk("b2b_c3_ackv", ack_valid[1], 1'b0);
    @(negedge clk);
    chk("b2b_c4_retry", req_retry[1], 1'b1);
    chk("b2b_c4_ackv", ack_valid[1], 1'b0);
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("b2b_c5_ackv", ack_valid[1], 1'b1);
    chk("b2b_c5_data", ack_data[1], l2);
    chk("b2b_c5_addr", ack_addr[1], 59'h2);
    @(negedge clk);
    chk("b2b_c6_ackv", ack_valid[1], 1'b0);
    chk("b2b_c6_retry", req_retry[1], 1'b0);

    // A few random transactions on the LATENCY=1 unit.
    for (int t = 0; t < 10; t++) begin
      a = 59'($urandom_range(1, 2));
      if ($urandom_range(0, 3) == 0) a = a | (59'd1 << ($urandom_range(AB, 58)));
      w = $urandom_range(0, 1) == 1;
      txn(1, w, a, rnd_line(), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
